ee354_ssd_scan_ctrl: RTL and testbench

//   Parametrised seven-segment scan controller: drives NUM_DIGITS multiplexed digits (max 8)

---
 rtl/ee354_ssd_scan_ctrl_pkg.sv | 62 ++++++
 rtl/ee354_ssd_scan_ctrl_bin2bcd_seq.sv | 82 ++++++++
 rtl/ee354_ssd_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ee354_ssd_scan_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ee354_ssd_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ee354_ssd_scan_ctrl_pkg
//  Description : Shared definitions for the seven-segment scan controller:
//                active-low cathode patterns {a,b,c,d,e,f,g,dp}, the
//                nibble-to-segment decoder and the control FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ee354_ssd_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int         c_MAX_DIGITS = 8;

    localparam logic [7:0] c_SEG_0     = 8'b0000_0011;
    localparam logic [7:0] c_SEG_1     = 8'b1001_1111;
    localparam logic [7:0] c_SEG_2     = 8'b0010_0101;
    localparam logic [7:0] c_SEG_3     = 8'b0000_1101;
    localparam logic [7:0] c_SEG_4     = 8'b1001_1001;
    localparam logic [7:0] c_SEG_5     = 8'b0100_1001;
    localparam logic [7:0] c_SEG_6     = 8'b0100_0001;
    localparam logic [7:0] c_SEG_7     = 8'b0001_1111;
    localparam logic [7:0] c_SEG_8     = 8'b0000_0001;
    localparam logic [7:0] c_SEG_9     = 8'b0000_1001;
    localparam logic [7:0] c_SEG_A     = 8'b0001_0001;
    localparam logic [7:0] c_SEG_B     = 8'b1100_0001;
    localparam logic [7:0] c_SEG_C     = 8'b0110_0011;
    localparam logic [7:0] c_SEG_D     = 8'b1000_0101;
    localparam logic [7:0] c_SEG_E     = 8'b0110_0001;
    localparam logic [7:0] c_SEG_F     = 8'b0111_0001;
    localparam logic [7:0] c_SEG_DASH  = 8'b1111_1101;
    localparam logic [7:0] c_SEG_BLANK = 8'b1111_1111;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = c_SEG_0;
            4'h1:    seg = c_SEG_1;
            4'h2:    seg = c_SEG_2;
            4'h3:    seg = c_SEG_3;
            4'h4:    seg = c_SEG_4;
            4'h5:    seg = c_SEG_5;
            4'h6:    seg = c_SEG_6;
            4'h7:    seg = c_SEG_7;
            4'h8:    seg = c_SEG_8;
            4'h9:    seg = c_SEG_9;
            4'hA:    seg = c_SEG_A;
            4'hB:    seg = c_SEG_B;
            4'hC:    seg = c_SEG_C;
            4'hD:    seg = c_SEG_D;
            4'hE:    seg = c_SEG_E;
            default: seg = c_SEG_F;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ee354_ssd_scan_ctrl_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ee354_bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter, one bit
//                per cycle. Start loads Value; Done is high during the cycle
//                the last iteration is applied, so Bcd/Overflow are final on
//                the following cycle. Overflow is sticky for the conversion.
//  Ports       : Clk, Reset_n (async, active-low), Start, Value -> Done,
//                Bcd (NUM_DIGITS nibbles, nibble 0 = units), Overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module ee354_bin2bcd_seq #(
    parameter int VALUE_W    = 8,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic [VALUE_W-1:0]      Value,
    output logic                    Done,
    output logic [4*NUM_DIGITS-1:0] Bcd,
    output logic                    Overflow
);

    localparam int                 c_BCD_W = 4 * NUM_DIGITS;
    localparam int                 c_W     = c_BCD_W + VALUE_W;
    localparam int                 c_CNT_W = $clog2(VALUE_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(VALUE_W - 1);

    logic [c_BCD_W-1:0] r_bcd;
    logic [VALUE_W-1:0] r_bin;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_active;
    logic               r_ovf;

    logic [c_BCD_W-1:0] w_adj;
    logic [c_W-1:0]     w_cat;
    logic [c_W-1:0]     w_sh;

    // Add-3 correction on every nibble that would reach >= 10 after the shift
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                     (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];
        end
    endgenerate

    assign w_cat = {w_adj, r_bin};
    assign w_sh  = {w_cat[c_W-2:0], 1'b0};
    assign Done  = r_active && (r_cnt == c_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_bcd    <= '0;
            r_bin    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (Start) begin
            r_bcd    <= '0;
            r_bin    <= Value;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_ovf    <= 1'b0;
        end else if (r_active) begin
            r_bcd <= w_sh[c_W-1:VALUE_W];
            r_bin <= w_sh[VALUE_W-1:0];
            r_cnt <= r_cnt + 1'b1;
            // A carry out of the top digit means the value needs more digits
            r_ovf <= r_ovf | w_cat[c_W-1];
            if (Done) begin
                r_active <= 1'b0;
            end
        end
    end

    assign Bcd      = r_bcd;
    assign Overflow = r_ovf;

endmodule
`default_nettype wire

// File: rtl/ee354_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ee354_ssd_scan_ctrl
//  Description : Multiplexed seven-segment scan controller. Converts a binary
//                Value to decimal (sequential) or hex digits on Load, holds
//                them in a display register and scans them onto An/Seg with
//                leading-zero blanking, per-digit blink and overflow dashes.
//  Ports       : Clk, Reset_n (async, active-low), Value, Load, Hex_Mode,
//                Blink_En, Blink[NUM_DIGITS-1:0] -> Busy, Overflow,
//                An[7:0] (active-low anodes), Seg[7:0] (active-low cathodes)
//  Revision    : 1.0 - initial release
// ============================================================================
module ee354_ssd_scan_ctrl
    import ee354_ssd_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 8,
    parameter int SCAN_DIV   = 18,
    parameter int BLINK_DIV  = 25,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [VALUE_W-1:0]    Value,
    input  logic                  Load,
    input  logic                  Hex_Mode,
    input  logic                  Blink_En,
    input  logic [NUM_DIGITS-1:0] Blink,
    output logic                  Busy,
    output logic                  Overflow,
    output logic [7:0]            An,
    output logic [7:0]            Seg
);

    localparam int c_DW = 4 * NUM_DIGITS;

    state_t                r_state;
    state_t                w_next;
    logic                  w_start;
    logic [VALUE_W-1:0]    r_value;
    logic                  r_hex;

    logic                  w_conv_done;
    logic [c_DW-1:0]       w_bcd;
    logic                  w_conv_ovf;

    logic [c_DW-1:0]       r_disp;
    logic [NUM_DIGITS-1:0] r_blank;
    logic                  r_ovf;

    logic [31:0]           w_val_ext;
    logic [c_DW-1:0]       w_new_digits;
    logic                  w_new_ovf;
    logic [NUM_DIGITS-1:0] w_new_blank;

    logic [SCAN_DIV-1:0]   r_presc;
    logic [2:0]            r_idx;
    logic [BLINK_DIV-1:0]  r_blink_cnt;
    logic                  r_phase;

    logic [3:0]            w_cur_digit;
    logic                  w_cur_blank;
    logic                  w_cur_blink;
    logic [7:0]            w_an_next;
    logic [7:0]            w_seg_next;
    logic [7:0]            r_an;
    logic [7:0]            r_seg;

    ee354_bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (w_start),
        .Value    (Value),
        .Done     (w_conv_done),
        .Bcd      (w_bcd),
        .Overflow (w_conv_ovf)
    );

    // ------------------------------------------------------------ control FSM
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_value <= '0;
            r_hex   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && Load) begin
                r_value <= Value;
                r_hex   <= Hex_Mode;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Load) begin
                    w_next  = Hex_Mode ? ST_COMMIT : ST_CONV;
                    w_start = !Hex_Mode;
                end
            end
            ST_CONV: begin
                if (w_conv_done) begin
                    w_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign Busy = (r_state != ST_IDLE);

    // ------------------------------------------------------ commit candidates
    assign w_val_ext    = 32'(r_value);
    assign w_new_digits = r_hex ? w_val_ext[c_DW-1:0] : w_bcd;
    assign w_new_ovf    = r_hex ? (|(w_val_ext >> c_DW)) : w_conv_ovf;

    // A digit is blank when it and everything above it are zero. While
    // overflowing every digit carries a dash, so zero blanking is suppressed.
    always_comb begin
        logic w_run;
        w_new_blank = '0;
        w_run       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run          = w_run && (w_new_digits[4*i +: 4] == 4'd0);
            w_new_blank[i] = (BLANK_LZ != 0) && !w_new_ovf && w_run;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_disp  <= '0;
            r_blank <= '1;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            r_disp  <= w_new_digits;
            r_blank <= w_new_blank;
            r_ovf   <= w_new_ovf;
        end
    end

    assign Overflow = r_ovf;

    // --------------------------------------------------- scan / blink timing
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_presc     <= '0;
            r_idx       <= 3'd0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_presc     <= r_presc + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (&r_presc) begin
                r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : (r_idx + 3'd1);
            end
            if (&r_blink_cnt) begin
                r_phase <= ~r_phase;
            end
        end
    end

    // ----------------------------------------------------------- output mux
    always_comb begin
        w_cur_digit = 4'd0;
        w_cur_blank = 1'b1;
        w_cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_cur_digit = r_disp[4*i +: 4];
                w_cur_blank = r_blank[i];
                w_cur_blink = Blink[i];
            end
        end
    end

    always_comb begin
        w_an_next  = 8'hFF;
        w_seg_next = c_SEG_BLANK;
        if (!w_cur_blank) begin
            w_seg_next = r_ovf ? c_SEG_DASH : hex_to_seg(w_cur_digit);
            if (!(Blink_En && w_cur_blink && r_phase)) begin
                w_an_next[r_idx] = 1'b0;
            end
        end
    end

    // An and Seg share one register stage so they always switch together
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign An  = r_an;
    assign Seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_ee354_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ee354_ssd_scan_ctrl
//  Description : Self-checking bench. Three controllers (4, 2 and 3 digits)
//                share the stimulus; expected digits are pushed to a queue at
//                each accepted Load and popped when the scanned display is
//                observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ee354_ssd_scan_ctrl;

    localparam int NINST = 3;

    logic       clk;
    logic       rst_n;
    logic [7:0] value;
    logic       load;
    logic       hex_mode;
    logic       blink_en;
    logic [3:0] blink;

    logic [7:0] an_o   [NINST];
    logic [7:0] seg_o  [NINST];
    logic       busy_o [NINST];
    logic       ovf_o  [NINST];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         inst;
        int         dig;
        bit         lit;
        logic [7:0] seg;
    } exp_t;

    exp_t sb_q [$];
    bit   exp_ovf [NINST];

    ee354_ssd_scan_ctrl #(.NUM_DIGITS(4), .VALUE_W(8), .SCAN_DIV(3), .BLINK_DIV(6), .BLANK_LZ(1)) u_d4 (
        .Clk(clk), .Reset_n(rst_n), .Value(value), .Load(load), .Hex_Mode(hex_mode),
        .Blink_En(blink_en), .Blink(blink), .Busy(busy_o[0]), .Overflow(ovf_o[0]),
        .An(an_o[0]), .Seg(seg_o[0]));

    ee354_ssd_scan_ctrl #(.NUM_DIGITS(2), .VALUE_W(8), .SCAN_DIV(3), .BLINK_DIV(6), .BLANK_LZ(1)) u_d2 (
        .Clk(clk), .Reset_n(rst_n), .Value(value), .Load(load), .Hex_Mode(hex_mode),
        .Blink_En(blink_en), .Blink(blink[1:0]), .Busy(busy_o[1]), .Overflow(ovf_o[1]),
        .An(an_o[1]), .Seg(seg_o[1]));

    ee354_ssd_scan_ctrl #(.NUM_DIGITS(3), .VALUE_W(8), .SCAN_DIV(3), .BLINK_DIV(6), .BLANK_LZ(1)) u_d3 (
        .Clk(clk), .Reset_n(rst_n), .Value(value), .Load(load), .Hex_Mode(hex_mode),
        .Blink_En(blink_en), .Blink(blink[2:0]), .Busy(busy_o[2]), .Overflow(ovf_o[2]),
        .An(an_o[2]), .Seg(seg_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nd_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic [7:0] ref_seg(input int d);
        case (d)
            0: return 8'b00000011;   1: return 8'b10011111;
            2: return 8'b00100101;   3: return 8'b00001101;
            4: return 8'b10011001;   5: return 8'b01001001;
            6: return 8'b01000001;   7: return 8'b00011111;
            8: return 8'b00000001;   9: return 8'b00001001;
            10: return 8'b00010001;  11: return 8'b11000001;
            12: return 8'b01100011;  13: return 8'b10000101;
            14: return 8'b01100001;  default: return 8'b01110001;
        endcase
    endfunction

    // Reference model: arithmetic digit extraction per instance
    task automatic push_expected(input int val, input bit hx);
        for (int k = 0; k < NINST; k++) begin
            int base = hx ? 16 : 10;
            int lim  = 1;
            bit ovf;
            for (int j = 0; j < nd_of(k); j++) lim = lim * base;
            ovf        = (val >= lim);
            exp_ovf[k] = ovf;
            for (int i = 0; i < nd_of(k); i++) begin
                int   pw = 1;
                exp_t e;
                for (int j = 0; j < i; j++) pw = pw * base;
                e.inst = k;
                e.dig  = i;
                e.lit  = ovf || (i == 0) || ((val / pw) != 0);
                e.seg  = ovf ? 8'hFD : ref_seg((val / pw) % base);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic do_load(input int val, input bit hx, input bit accept);
        @(negedge clk);
        value    = val[7:0];
        hex_mode = hx;
        load     = 1'b1;
        if (accept) push_expected(val, hx);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_o[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_display(input string tag);
        bit         lit_obs [NINST][8];
        logic [7:0] seg_obs [NINST][8];
        int         bad     [NINST];
        repeat (2) @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            bad[k] = 0;
            for (int d = 0; d < 8; d++) begin
                lit_obs[k][d] = 1'b0;
                seg_obs[k][d] = 8'hFF;
            end
        end
        for (int c = 0; c < 34; c++) begin
            for (int k = 0; k < NINST; k++) begin
                int zc  = 0;
                int pos = 0;
                for (int b = 0; b < 8; b++) begin
                    if (an_o[k][b] == 1'b0) begin
                        zc++;
                        pos = b;
                    end
                end
                if (zc > 1 || (zc == 1 && pos >= nd_of(k))) bad[k]++;
                if (zc == 0 && seg_o[k] !== 8'hFF) bad[k]++;
                if (zc == 1) begin
                    lit_obs[k][pos] = 1'b1;
                    seg_obs[k][pos] = seg_o[k];
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < NINST; k++) begin
            checks++;
            if (bad[k] != 0) begin
                failures++;
                $display("FAIL %s an_shape inst%0d: got %0d bad samples, expected 0", tag, k, bad[k]);
            end
            checks++;
            if (ovf_o[k] !== exp_ovf[k]) begin
                failures++;
                $display("FAIL %s overflow inst%0d: got %b expected %b", tag, k, ovf_o[k], exp_ovf[k]);
            end
        end
        while (sb_q.size() > 0) begin
            exp_t e = sb_q.pop_front();
            checks++;
            if (lit_obs[e.inst][e.dig] !== e.lit ||
                (e.lit && seg_obs[e.inst][e.dig] !== e.seg)) begin
                failures++;
                $display("FAIL %s digit inst%0d d%0d: got lit=%b seg=%b expected lit=%b seg=%b",
                         tag, e.inst, e.dig, lit_obs[e.inst][e.dig], seg_obs[e.inst][e.dig],
                         e.lit, e.seg);
            end
        end
    endtask

    task automatic check_busy(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            checks++;
            if (an_o[k] !== 8'hFF || seg_o[k] !== 8'hFF || busy_o[k] !== 1'b0 || ovf_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state inst%0d: got an=%h seg=%h busy=%b ovf=%b expected FF FF 0 0",
                         k, an_o[k], seg_o[k], busy_o[k], ovf_o[k]);
            end
        end
        rst_n = 1'b1;
        begin
            int lit = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                for (int k = 0; k < NINST; k++) if (an_o[k] !== 8'hFF) lit++;
            end
            checks++;
            if (lit != 0) begin
                failures++;
                $display("FAIL reset_blank: got %0d lit samples expected 0", lit);
            end
        end
    endtask

    task automatic test_decimal();
        int n;
        do_load(225, 1'b0, 1'b1);
        wait_idle(n);
        check_busy("dec225", n, 9);
        check_display("dec225");
    endtask

    task automatic test_blank_zero();
        int n;
        do_load(7, 1'b0, 1'b1);
        wait_idle(n);
        check_display("dec7");
        do_load(0, 1'b0, 1'b1);
        wait_idle(n);
        check_display("dec0");
    endtask

    task automatic test_overflow();
        int n;
        do_load(100, 1'b0, 1'b1);
        wait_idle(n);
        check_display("dec100");
        do_load(99, 1'b0, 1'b1);
        wait_idle(n);
        check_display("dec99");
    endtask

    task automatic test_hex_wrap();
        int         n;
        bit         found = 1'b0;
        logic [7:0] prev;
        logic [7:0] exp_seq [4] = '{8'hFE, 8'hFD, 8'hFF, 8'hFE};
        int         offs    [4] = '{7, 1, 8, 8};
        do_load(8'hAB, 1'b1, 1'b1);
        wait_idle(n);
        check_busy("hexAB", n, 1);
        check_display("hexAB");
        // Find the first cycle of a digit-0 dwell on the 3-digit instance
        prev = an_o[2];
        n    = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (an_o[2] === 8'hFE && prev !== 8'hFE) found = 1'b1;
            prev = an_o[2];
            n++;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wrap_sync: got no digit0 dwell start expected one within 100 cycles");
        end
        for (int s = 0; s < 4; s++) begin
            repeat (offs[s]) @(negedge clk);
            checks++;
            if (an_o[2] !== exp_seq[s]) begin
                failures++;
                $display("FAIL wrap_step%0d: got an=%h expected %h", s, an_o[2], exp_seq[s]);
            end
        end
    endtask

    task automatic test_load_during_busy();
        int n;
        do_load(123, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        value = 8'd45;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        check_busy("busy_load", n, 5);
        check_display("busy_load");
    endtask

    task automatic count_an0(output int c4, output int c2);
        c4 = 0;
        c2 = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            if (an_o[0][0] == 1'b0) c4++;
            if (an_o[1][0] == 1'b0) c2++;
        end
    endtask

    task automatic test_blink();
        int n;
        int c4;
        int c2;
        do_load(7, 1'b0, 1'b1);
        wait_idle(n);
        check_display("blink_val");
        count_an0(c4, c2);
        checks++;
        if (c4 != 64 || c2 != 128) begin
            failures++;
            $display("FAIL no_blink_duty: got %0d/%0d expected 64/128", c4, c2);
        end
        blink    = 4'b0001;
        blink_en = 1'b1;
        count_an0(c4, c2);
        checks++;
        if (c4 != 32 || c2 != 64) begin
            failures++;
            $display("FAIL blink_duty: got %0d/%0d expected 32/64", c4, c2);
        end
        blink_en = 1'b0;
        blink    = 4'b0000;
    endtask

    task automatic test_async_reset();
        int n;
        int lit = 0;
        do_load(255, 1'b0, 1'b1);
        wait_idle(n);
        check_display("pre_reset");
        do_load(200, 1'b0, 1'b0);
        @(negedge clk);
        n = 0;
        while (an_o[0] === 8'hFF && n < 7) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_reset: got %b expected 1", busy_o[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NINST; k++) begin
            checks++;
            if (an_o[k] !== 8'hFF || seg_o[k] !== 8'hFF || busy_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL async_reset inst%0d: got an=%h seg=%h busy=%b expected FF FF 0",
                         k, an_o[k], seg_o[k], busy_o[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < NINST; k++) if (an_o[k] !== 8'hFF || busy_o[k] !== 1'b0) lit++;
        end
        checks++;
        if (lit != 0) begin
            failures++;
            $display("FAIL post_reset_blank: got %0d active samples expected 0", lit);
        end
        do_load(42, 1'b0, 1'b1);
        wait_idle(n);
        check_busy("after_reset", n, 9);
        check_display("after_reset");
    endtask

    initial begin
        rst_n    = 1'b0;
        value    = 8'd0;
        load     = 1'b0;
        hex_mode = 1'b0;
        blink_en = 1'b0;
        blink    = 4'b0000;
        test_reset();
        test_decimal();
        test_blank_zero();
        test_overflow();
        test_hex_wrap();
        test_load_during_busy();
        test_blink();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
